// File: rtl/mealy_seq_detect.sv
// Mealy serial pattern detector: flags the cycle whose input bit completes PATTERN
// (overlaps allowed) and keeps a saturating count of hits.
module mealy_seq_detect #(
    parameter int unsigned        PAT_LEN = 3,
    parameter logic [PAT_LEN-1:0] PATTERN = 3'b101,
    parameter int unsigned        CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             x,
    output logic             z,
    output logic [CNT_W-1:0] match_count
);

    localparam int unsigned SW    = (PAT_LEN > 2) ? $clog2(PAT_LEN) : 1;
    localparam int unsigned TBL_N = 2 ** (SW + 1);
    localparam logic [SW-1:0] LAST_STATE = SW'(PAT_LEN - 1);

    // Next state after seeing bit b in state k: longest prefix of PATTERN that is a
    // suffix of (first k pattern bits + b), capped below a full match.
    function automatic int unsigned next_f(input int unsigned k, input int unsigned b);
        int unsigned pat;
        int unsigned seen;
        int unsigned lim;
        int unsigned best;
        pat  = 32'(PATTERN);
        seen = ((pat >> (PAT_LEN - k)) << 1) | b;
        lim  = (k + 1 < PAT_LEN) ? k + 1 : PAT_LEN - 1;
        best = 0;
        for (int unsigned l = 1; l <= lim; l++) begin
            if ((seen & ((32'd1 << l) - 1)) == (pat >> (PAT_LEN - l))) best = l;
        end
        return best;
    endfunction

    logic [SW-1:0] current_state;
    logic [SW-1:0] next_state;
    logic [SW-1:0] nxt_tbl [TBL_N];

    // Transition table indexed by {state, x}; unreachable codes fall back to 0.
    for (genvar i = 0; i < TBL_N; i++) begin : g_tbl
        if (i < int'(2 * PAT_LEN)) begin : g_valid
            localparam int unsigned NXT = next_f(32'(i / 2), 32'(i % 2));
            assign nxt_tbl[i] = SW'(NXT);
        end else begin : g_pad
            assign nxt_tbl[i] = '0;
        end
    end

    assign next_state = nxt_tbl[{current_state, x}];

    // Reset gates z so a held-low rst never reports a hit.
    assign z = rst & (current_state == LAST_STATE) & (x == PATTERN[0]);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            current_state <= '0;
            match_count   <= '0;
        end else begin
            current_state <= next_state;
            if (z && (match_count != '1)) match_count <= match_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_mealy_seq_detect.sv
// Directed bench for mealy_seq_detect: default "101", a 2-bit counter copy and a "1101" copy,
// each checked against a stream-history model plus hand-computed literals.
module tb_mealy_seq_detect;

    logic       clk = 1'b0;
    logic       rst_a, rst_b, rst_c;
    logic       x_a, x_b, x_c;
    logic       z_a, z_b, z_c;
    logic [7:0] cnt_a;
    logic [1:0] cnt_b;
    logic [7:0] cnt_c;

    mealy_seq_detect u0 (.clk(clk), .rst(rst_a), .x(x_a), .z(z_a), .match_count(cnt_a));
    mealy_seq_detect #(.CNT_W(2)) u1 (.clk(clk), .rst(rst_b), .x(x_b), .z(z_b), .match_count(cnt_b));
    mealy_seq_detect #(.PAT_LEN(4), .PATTERN(4'b1101)) u2
        (.clk(clk), .rst(rst_c), .x(x_c), .z(z_c), .match_count(cnt_c));

    always #10 clk = ~clk;

    int          sel;
    int          n_vec;
    int          n_fail;
    int unsigned hbits;
    int unsigned hlen;
    int unsigned cnt;
    int unsigned st_trace [16];
    bit          trace_en;

    function automatic int unsigned cur_pat();
        return (sel == 2) ? 32'd13 : 32'd5;
    endfunction

    function automatic int unsigned cur_len();
        return (sel == 2) ? 32'd4 : 32'd3;
    endfunction

    function automatic int unsigned cur_max();
        return (sel == 1) ? 32'd3 : 32'd255;
    endfunction

    // Hit when the last len bits of history+x spell the pattern.
    function automatic int unsigned model_hit(input int unsigned h, input int unsigned hl,
                                              input bit xv);
        int unsigned s;
        int unsigned len;
        len = cur_len();
        s   = (h << 1) | 32'(xv);
        return ((hl + 1 >= len) && ((s & ((32'd1 << len) - 1)) == cur_pat())) ? 32'd1 : 32'd0;
    endfunction

    // Matched-so-far: longest history suffix that is a proper pattern prefix.
    function automatic int unsigned model_state(input int unsigned h, input int unsigned hl);
        int unsigned best;
        int unsigned len;
        len  = cur_len();
        best = 0;
        for (int unsigned l = 1; l < len; l++) begin
            if (l <= hl && ((h & ((32'd1 << l) - 1)) == (cur_pat() >> (len - l)))) best = l;
        end
        return best;
    endfunction

    task automatic cmp(input string name, input int unsigned act, input int unsigned exp);
        n_vec++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s (dut %0d): got %0d expected %0d at %0t", name, sel, act, exp, $time);
        end
    endtask

    task automatic read_dut(output int unsigned az, output int unsigned ac,
                            output int unsigned ast, output bit r, output bit xv);
        case (sel)
            0:       begin az = 32'(z_a); ac = 32'(cnt_a); ast = 32'(u0.current_state); r = rst_a; xv = x_a; end
            1:       begin az = 32'(z_b); ac = 32'(cnt_b); ast = 32'(u1.current_state); r = rst_b; xv = x_b; end
            default: begin az = 32'(z_c); ac = 32'(cnt_c); ast = 32'(u2.current_state); r = rst_c; xv = x_c; end
        endcase
    endtask

    task automatic set_x(input bit v);
        case (sel)
            0:       x_a = v;
            1:       x_b = v;
            default: x_c = v;
        endcase
    endtask

    task automatic set_rst(input bit v);
        case (sel)
            0:       rst_a = v;
            1:       rst_b = v;
            default: rst_c = v;
        endcase
        if (!v) begin
            hbits = 0;
            hlen  = 0;
            cnt   = 0;
        end
    endtask

    task automatic check_model();
        int unsigned az, ac, ast;
        bit r, xv;
        read_dut(az, ac, ast, r, xv);
        cmp("z", az, r ? model_hit(hbits, hlen, xv) : 32'd0);
        cmp("state", ast, model_state(hbits, hlen));
        cmp("count", ac, cnt);
    endtask

    // Model advance on the rising edge that consumes x.
    task automatic consume();
        int unsigned az, ac, ast;
        bit r, xv;
        read_dut(az, ac, ast, r, xv);
        if (r) begin
            if (model_hit(hbits, hlen, xv) == 1 && cnt < cur_max()) cnt++;
            hbits = ((hbits << 1) | 32'(xv)) & 32'hFFFF;
            if (hlen < 16) hlen++;
        end
    endtask

    // Entered just after a rising edge; leaves just after the edge consuming the last bit.
    task automatic run_stream(input int n, input logic [15:0] bits, input logic [15:0] zexp);
        int unsigned az, ac, ast;
        bit r, xv;
        for (int i = 0; i < n; i++) begin
            set_x(bits[4'(n - 1 - i)]);
            @(negedge clk);
            check_model();
            read_dut(az, ac, ast, r, xv);
            cmp("z_lit", az, 32'(zexp[4'(n - 1 - i)]));
            @(posedge clk);
            consume();
            #1;
            if (trace_en) begin
                read_dut(az, ac, ast, r, xv);
                cmp("state_lit", ast, st_trace[i]);
            end
        end
    endtask

    task automatic reset_phase(input int cycles);
        set_rst(1'b0);
        for (int i = 0; i < cycles; i++) begin
            set_x(1'b1);
            @(negedge clk);
            check_model();
            @(posedge clk);
            consume();
            #1;
        end
        set_rst(1'b1);
    endtask

    initial begin
        int unsigned az, ac, ast;
        bit r, xv;
        n_vec = 0; n_fail = 0; trace_en = 0;
        rst_a = 0; rst_b = 0; rst_c = 0;
        x_a = 1; x_b = 1; x_c = 1;
        sel = 0; hbits = 0; hlen = 0; cnt = 0;
        @(posedge clk);
        #1;

        // Default pattern: overlapping stream with literal z and state trace.
        sel = 0;
        reset_phase(3);
        st_trace = '{0, 1, 2, 1, 2, 1, 1, 2, 1, 1, 1, 2, 1, 2, 1, 0};
        trace_en = 1;
        run_stream(15, 16'b0010101101110101, 16'b0000101001000101);
        trace_en = 0;
        read_dut(az, ac, ast, r, xv);
        cmp("count_lit", ac, 5);

        // Reach "10", then pulse reset between edges with x=1.
        run_stream(2, 16'b10, 16'b00);
        read_dut(az, ac, ast, r, xv);
        cmp("state_lit", ast, 2);
        set_x(1'b1);
        #2;
        set_rst(1'b0);
        #2;
        read_dut(az, ac, ast, r, xv);
        cmp("z_in_reset", az, 0);
        cmp("state_in_reset", ast, 0);
        cmp("count_in_reset", ac, 0);
        #2;
        set_rst(1'b1);
        st_trace[0] = 1;
        trace_en = 1;
        run_stream(1, 16'b1, 16'b0);

        // Non-matching stream; "100" must return to state 0.
        reset_phase(1);
        st_trace = '{1, 2, 0, 1, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        run_stream(7, 16'b1001100, 16'b0);
        trace_en = 0;
        read_dut(az, ac, ast, r, xv);
        cmp("count_lit", ac, 0);
        set_rst(1'b0);

        // 2-bit counter saturates at 3 after five hits.
        sel = 1;
        reset_phase(2);
        run_stream(11, 16'b10101010101, 16'b00101010101);
        read_dut(az, ac, ast, r, xv);
        cmp("count_sat_lit", ac, 3);
        set_rst(1'b0);

        // Four-bit pattern 1101 with overlap.
        sel = 2;
        reset_phase(2);
        st_trace = '{1, 2, 3, 1, 2, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        trace_en = 1;
        run_stream(7, 16'b1101101, 16'b0001001);
        trace_en = 0;
        read_dut(az, ac, ast, r, xv);
        cmp("count_lit", ac, 2);
        set_rst(1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
